rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Reset sequencer for the design's flop banks.
//  - Takes the chip-level asynchronous reset and synchronises its deassertion.
//  - Releases NUM_DOMAINS downstream active-low resets one at a time, spaced GAP_CYCLES apart.
//  - Supports a software-requested re-reset of all domains once sequencing is done.
//  - Sits between the reset pin and every always_ff block that uses an async active-low reset.
// PARAMETERS
//  NUM_DOMAINS   4   number of sequenced reset domains (>=1)
//  SYNC_STAGES   2   synchroniser depth on reset deassertion (>=2)
//  GAP_CYCLES    8   clk cycles between consecutive domain releases (>=1)
//  HOLD_CYCLES   4   cycles all domains are held during a software reset (>=1)
// PORTS
//  clk           in   1            system clock
//  reset         in   1            asynchronous, active-low reset
//  sw_rst_req_i  in   1            software reset request, single-cycle pulse
//  domain_en_i   in   NUM_DOMAINS  1 = domain is released in its slot; 0 = domain is held
//  rst_n_o       out  NUM_DOMAINS  per-domain active-low reset, registered
//  done_o        out  1            sequence complete, level
//  rel_idx_o     out  IDX_W        index of the next slot to release; IDX_W=$clog2(NUM_DOMAINS+1)
// BEHAVIOUR
//  Reset (reset=0), asynchronous and immediate:
//  - rst_n_o=0, done_o=0, rel_idx_o=0.
//  - Synchroniser chain=0, counter=0, state=HOLD.
//  Synchroniser:
//  - Chain shifts in 1 each edge while reset=1.
//  - sync_ok goes high SYNC_STAGES edges after reset deasserts.
//  - Edge 1 is the first posedge with reset=1.
//  FSM states: HOLD, GAP, DONE, SW_HOLD.
//  - HOLD: wait for sync_ok=1, then go to GAP with cnt=0 and idx=0.
//  - GAP: cnt increments each cycle. On the edge where cnt==GAP_CYCLES-1:
//    - rst_n_o[idx] <= domain_en_i[idx] (sampled at that edge only);
//    - cnt <= 0, idx <= idx+1;
//    - if idx==NUM_DOMAINS-1, go to DONE and set done_o=1 on the same edge.
//  - Domain i deasserts on edge SYNC_STAGES+1+(i+1)*GAP_CYCLES.
//    - Defaults: edges 11, 19, 27, 35.
//  - Disabled domains still consume their slot. Their rst_n_o stays 0 until the next full sequence.
//  - DONE:
//    - rst_n_o holds; changes on domain_en_i are ignored.
//    - sw_rst_req_i=1 -> next edge: rst_n_o=0 (all bits), done_o=0, idx=0, cnt=0, state SW_HOLD.
//  - SW_HOLD: hold for HOLD_CYCLES cycles (cnt 0..HOLD_CYCLES-1), then GAP with cnt=0.
//    - Release timing from that point is identical to power-on sequencing.
//  - sw_rst_req_i is ignored in HOLD, GAP and SW_HOLD (no queueing).
//  rel_idx_o:
//  - equals idx;
//  - reads NUM_DOMAINS in DONE;
//  - reads 0 in HOLD and SW_HOLD.
//  Boundaries:
//  - reset asserted mid-sequence: all outputs clear asynchronously; the full sequence restarts after deassertion.
//  - reset glitch shorter than a cycle: still clears the chain; the full sequence restarts.
//  - GAP_CYCLES=1: one domain is released per edge.
//  - NUM_DOMAINS=1: DONE is reached with the single release.
//  - rst_n_o only ever goes 0->1 in GAP, and only at a terminal-count edge.
//  - Counter width: $clog2(max(GAP_CYCLES,HOLD_CYCLES)+1). No wrap past the terminal count.
// STRUCTURE
//  Package rst_seq_pkg:
//  - typedef enum logic [1:0] {HOLD,GAP,DONE,SW_HOLD} rst_seq_state_e;
//  - function idx_w(n) returning $clog2(n+1).
//  Sub-module rst_sync (parameter STAGES):
//  - async assert, sync deassert chain; output sync_ok.
//  FSM, counter, idx and the rst_n_o register stay in rst_seq_ctrl. All flops use reset async active-low.
// TESTING
//  1 Power-on, defaults, all domains enabled:
//    - reset low 3 cycles, then high;
//    - rst_n_o bits rise at edges 11/19/27/35;
//    - done_o=1 at edge 35, rel_idx_o=4.
//  2 domain_en_i=4'b1010:
//    - rst_n_o ends at 4'b1010;
//    - done_o still rises at edge 35;
//    - bits 0 and 2 stay low.
//  3 Software reset in DONE (pulse sw_rst_req_i at edge N):
//    - edge N+1: rst_n_o=0, done_o=0;
//    - domain0 rises at N+1+4+8, last at N+1+4+32.
//  4 sw_rst_req_i pulsed during GAP:
//    - ignored; timing identical to test 1.
//  5 reset pulsed low mid-GAP after domain1 is released:
//    - rst_n_o=0 immediately (no clk edge);
//    - after deassertion, full sequence replays with test-1 timing.
//  6 domain_en_i toggled in DONE:
//    - rst_n_o unchanged.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        GAP     = 2'd1,
        DONE    = 2'd2,
        SW_HOLD = 2'd3
    } rst_seq_state_e;

    // Width needed to hold the values 0..n inclusive.
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Counter width covering the larger of the gap and hold terminal counts.
    function automatic int cnt_w(input int gap, input int hold);
        return $clog2(((gap > hold) ? gap : hold) + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// Reset synchroniser: asserts asynchronously and releases sync_ok only after
// STAGES clock edges have shifted ones through the chain.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_ok
);

    logic [STAGES-1:0] r_chain;

    // Shift a 1 in on every edge while reset is high; any reset pulse empties the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = r_chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises chip reset deassertion, then releases the
// per-domain active-low resets one slot at a time, GAP_CYCLES apart.
// A software request taken in DONE re-runs the whole sequence after a hold.
//
// sw_rst_req_i is a single-cycle request with no ready: it is accepted only
// on an edge where the sequencer is in DONE; in every other state it is
// dropped, never queued.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sw_rst_req_i,
    input  logic [NUM_DOMAINS-1:0]           domain_en_i,
    output logic [NUM_DOMAINS-1:0]           rst_n_o,
    output logic                             done_o,
    output logic [idx_w(NUM_DOMAINS)-1:0]    rel_idx_o,
    output rst_seq_state_e                   dbg_state_o
);

    localparam int IDX_W = idx_w(NUM_DOMAINS);
    localparam int CNT_W = cnt_w(GAP_CYCLES, HOLD_CYCLES);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    rst_seq_state_e       r_state;
    rst_seq_state_e       w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_sync_ok;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .sync_ok (w_sync_ok)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot counter, release index, domain resets and done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; a domain's reset can only rise at a GAP terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = r_done;
        case (r_state)
            HOLD: begin
                if (w_sync_ok) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    // Disabled domains still use up their slot and stay in reset.
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            w_rst_n_nxt[i] = domain_en_i[i];
                        end
                    end
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_rst_req_i) begin
                    w_state_nxt = SW_HOLD;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            SW_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = HOLD;
            end
        endcase
    end

    assign rst_n_o     = r_rst_n;
    assign done_o      = r_done;
    assign rel_idx_o   = r_idx;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a timing model predicts every output change
// (edge number and values); a monitor pops and compares on each change.
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    localparam int ND = 4;
    localparam int SS = 2;
    localparam int G  = 8;
    localparam int H  = 4;
    localparam int IW = $clog2(ND + 1);
    localparam int OW = ND + 1 + IW;
    localparam int EW = 32 + OW;

    logic            clk = 1'b0;
    logic            reset;
    logic            sw_rst_req_i;
    logic [ND-1:0]   domain_en_i;
    logic [ND-1:0]   rst_n_o;
    logic            done_o;
    logic [IW-1:0]   rel_idx_o;
    rst_seq_state_e  dbg_state_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];
    logic [OW-1:0] prev_obs = '0;
    logic [OW-1:0] obs;
    logic [EW-1:0] ev;

    rst_seq_ctrl #(
        .NUM_DOMAINS (ND),
        .SYNC_STAGES (SS),
        .GAP_CYCLES  (G),
        .HOLD_CYCLES (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req_i (sw_rst_req_i),
        .domain_en_i  (domain_en_i),
        .rst_n_o      (rst_n_o),
        .done_o       (done_o),
        .rel_idx_o    (rel_idx_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / edge count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic push_ev(input int at, input logic [ND-1:0] r, input logic d, input int idx);
        exp_q.push_back({32'(at), r, d, IW'(idx)});
    endtask

    // Domain i's reset rises G*(i+1) edges after t0; done and idx track the slot.
    task automatic model_sequence(input int t0, input logic [ND-1:0] en);
        logic [ND-1:0] acc;
        acc = '0;
        for (int i = 0; i < ND; i++) begin
            acc[i] = en[i];
            push_ev(t0 + (i + 1) * G, acc, (i == ND - 1), i + 1);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        obs = {rst_n_o, done_o, rel_idx_o};
        if (obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got rst_n=%b done=%b idx=%0d expected no change",
                         cyc, rst_n_o, done_o, rel_idx_o);
            end else begin
                ev = exp_q.pop_front();
                if (ev !== {32'(cyc), obs}) begin
                    errors++;
                    $display("FAIL event cyc=%0d got rst_n=%b done=%b idx=%0d expected cyc=%0d rst_n=%b done=%b idx=%0d",
                             cyc, rst_n_o, done_o, rel_idx_o,
                             int'(ev[EW-1:OW]), ev[OW-1:IW+1], ev[IW], ev[IW-1:0]);
                end
            end
            prev_obs = obs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic power_on(input int low_cycles);
        int base;
        repeat (low_cycles) @(posedge clk);
        #1;
        base  = cyc;
        reset = 1'b1;
        model_sequence(base + SS + 1, domain_en_i);
    endtask

    task automatic sw_reset();
        int cur;
        @(posedge clk);
        #1;
        cur          = cyc;
        sw_rst_req_i = 1'b1;
        push_ev(cur + 1, '0, 1'b0, 0);
        model_sequence(cur + 1 + H, domain_en_i);
        @(posedge clk);
        #1;
        sw_rst_req_i = 1'b0;
    endtask

    task automatic sw_pulse_ignored();
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            sw_rst_req_i = 1'b1;
            @(posedge clk);
            #1;
            sw_rst_req_i = 1'b0;
        end
    endtask

    task automatic async_reset(input bit glitch, input int low_cycles);
        int cur;
        @(negedge clk);
        #1;
        cur   = cyc;
        reset = 1'b0;
        #1;
        check_val("async_rst_n", int'(rst_n_o), 0);
        check_val("async_done", int'(done_o), 0);
        check_val("async_idx", int'(rel_idx_o), 0);
        exp_q.delete();
        push_ev(cur + 1, '0, 1'b0, 0);
        if (glitch) begin
            #1;
            reset = 1'b1;
            model_sequence(cur + SS + 1, domain_en_i);
        end else begin
            power_on(low_cycles);
        end
    endtask

    task automatic wait_size_le(input int k);
        int n;
        n = 0;
        while (exp_q.size() > k && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() > k) begin
            errors++;
            $display("FAIL wait_events cyc=%0d got pending=%0d expected at most %0d", cyc, exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic done_toggle(input int n);
        logic [ND-1:0] keep;
        keep = domain_en_i;
        repeat (n) begin
            @(posedge clk);
            #1;
            domain_en_i = ND'($urandom);
        end
        @(negedge clk);
        check_val("done_level", int'(done_o), 1);
        domain_en_i = keep;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b0;
        sw_rst_req_i = 1'b0;
        domain_en_i  = '1;
        #1;
        check_val("reset_rst_n", int'(rst_n_o), 0);
        check_val("reset_done", int'(done_o), 0);
        check_val("reset_idx", int'(rel_idx_o), 0);

        // Power-on, everything enabled.
        power_on(3);
        wait_size_le(0);
        check_val("pwr_on_rst_n", int'(rst_n_o), 'hF);
        check_val("pwr_on_idx", int'(rel_idx_o), ND);

        // domain_en_i changes in DONE must not disturb anything.
        done_toggle(12);

        // Power-on with alternating enables.
        domain_en_i = 4'b1010;
        async_reset(1'b0, 3);
        wait_size_le(0);
        check_val("en1010_rst_n", int'(rst_n_o), 'hA);

        // Software reset from DONE.
        domain_en_i = '1;
        sw_reset();
        wait_size_le(0);

        // Software request during GAP is dropped.
        async_reset(1'b0, 3);
        wait_size_le(ND - 1);
        sw_pulse_ignored();
        wait_size_le(0);

        // Reset pulsed after domain1 released, sequence replays.
        sw_reset();
        wait_size_le(ND - 2);
        async_reset(1'b0, 2);
        wait_size_le(0);

        // Randomised mix of the above.
        for (int it = 0; it < 10; it++) begin
            int act;
            domain_en_i = ND'($urandom);
            act = $urandom_range(0, 3);
            sw_reset();
            if (act == 1) begin
                wait_size_le($urandom_range(1, ND));
                sw_pulse_ignored();
            end else if (act >= 2) begin
                wait_size_le($urandom_range(1, ND - 1));
                async_reset(act == 3, $urandom_range(1, 3));
            end
            wait_size_le(0);
            check_val("rand_rst_n", int'(rst_n_o), int'(domain_en_i));
            done_toggle($urandom_range(2, 6));
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
